// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum display slice: FSM state encoding,
// active-low segment patterns ({g,f,e,d,c,b,a}) and the BCD/sum widths.
package sum_display_pkg;

  localparam int BCD_W = 4;
  localparam int SUM_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next doubling, so it is pre-biased by 3.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/sum_display_mux_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern ({g,f,e,d,c,b,a}).
// Codes above 9 never reach this decoder; they show as blank.
module bcd_to_7seg
  import sum_display_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  // Look up the segment pattern for the selected digit.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_display_mux.sv
// Captures the 5-bit ripple-adder result {co, zi} on a load strobe, converts
// it to two BCD digits with a sequential shift-add-3 engine and drives a
// time-multiplexed 2-digit common-anode 7-segment display.
// Optional build macro SUM_DISPLAY_BLANK_EN: blank the tens digit when it is 0.
module sum_display_mux
  import sum_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CONV_STEPS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       co,
  input  logic [3:0] zi,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int STEP_W = $clog2(CONV_STEPS + 1);

  state_t state, state_next;

  logic [SUM_W-1:0]         bin;
  logic [2*BCD_W-1:0]       bcd;
  logic [2*BCD_W-1:0]       bcd_adj;
  logic [2*BCD_W+SUM_W-1:0] shifted;
  logic [STEP_W-1:0]        step;
  logic [BCD_W-1:0]         tens;
  logic [BCD_W-1:0]         units;

  logic [CNT_W-1:0]         refresh_cnt;
  logic                     digit_sel;
  logic [BCD_W-1:0]         digit_shown;
  logic [6:0]               seg_dec;

  // State register; reset aborts any conversion in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: load is only honoured in IDLE, so strobes during a
  // conversion or in FIN are dropped rather than queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (load) state_next = CONV;
      CONV: if (step == STEP_W'(CONV_STEPS - 1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // One double-dabble step: correct both nibbles, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = {add3(bcd[2*BCD_W-1:BCD_W]), add3(bcd[BCD_W-1:0])};
    shifted = {bcd_adj, bin} << 1;
  end

  // Conversion datapath and displayed digits; digits only change in FIN so
  // partial results never reach the display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin   <= '0;
      bcd   <= '0;
      step  <= '0;
      tens  <= '0;
      units <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin  <= {co, zi};
            bcd  <= '0;
            step <= '0;
          end
        end
        CONV: begin
          {bcd, bin} <= shifted;
          step       <= step + 1'b1;
        end
        FIN: begin
          tens  <= bcd[2*BCD_W-1:BCD_W];
          units <= bcd[BCD_W-1:0];
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Free-running refresh timer; each wrap hands the display to the other digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_sel   <= ~digit_sel;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // an and seg both derive from digit_sel, so they switch on the same edge.
  assign digit_shown = digit_sel ? tens : units;
  assign an          = digit_sel ? 2'b01 : 2'b10;

  bcd_to_7seg u_bcd_to_7seg (
    .digit (digit_shown),
    .seg   (seg_dec)
  );

`ifdef SUM_DISPLAY_BLANK_EN
  assign seg = (digit_sel && (tens == '0)) ? SEG_BLANK : seg_dec;
`else
  assign seg = seg_dec;
`endif

endmodule

// File: doc/sum_display_mux.md
Name: sum_display_mux

Overview:
- Downstream consumer of the 4-bit ripple adder result {co, zi}.
- On a load strobe it captures the 5-bit sum (0..31) and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- It then drives a time-multiplexed 2-digit common-anode 7-segment display on the lab board.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays enabled before switching to the other; minimum 2.
- CONV_STEPS, 5, number of shift iterations; equals the input width and is fixed for a 5-bit sum.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; sample {co, zi}.
- co  input  1  adder carry out, the sum MSB.
- zi  input  4  adder sum bits.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the new digits are displayed.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  2  digit enables, active-low; an[0] = units, an[1] = tens.

Behaviour:
- Reset (asynchronous, rst=0):
  - State IDLE; busy=0, done=0.
  - Both digit registers = 0.
  - Refresh counter = 0, digit select = units, so an=2'b10 and seg=7'b1000000 ("0").
- FSM has three states: IDLE, CONV, FIN.
  - IDLE: on load=1 at edge E0, capture bin={co,zi} and clear the 8-bit BCD shift register and the step counter. Go to CONV; busy=1 after E0.
  - CONV: each edge E1..E5 adds 3 to any BCD nibble >=5, then shifts {bcd,bin} left by 1 and increments the step counter. After the 5th shift (E5) go to FIN.
  - FIN: at the next edge (E6) copy the BCD nibbles to the tens/units digit registers and assert done=1 and busy=0 for exactly that cycle, then return to IDLE.
- Latency: load sampled at E0 -> new digits and done visible after E6.
- Digit registers hold their old values throughout CONV and FIN; there is no flicker of partial results.
- load while busy=1 or in FIN is ignored; there is no queueing.
- load in the same cycle that done is high is accepted (the state is IDLE again).
- Refresh counter runs 0..REFRESH_DIV-1, free-running and independent of the FSM.
  - At the terminal count it wraps to 0 and toggles the digit select.
  - an and seg change on the same edge, so there is no ghost cycle.
- Segment encoding for digits 0-9 (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Digit values above 9 cannot occur.
- Reset asserted mid-conversion aborts immediately. All outputs return to their reset values; the old digits are lost and read 0.

Optional Feature:
- SUM_DISPLAY_BLANK_EN: leading-zero blanking.
- Defined: when the tens digit is 0, seg=7'b1111111 during the tens slot. an[1] still toggles, so timing is unchanged.
- Undefined: the tens digit always shows, including "0".

Decomposition:
- Package sum_display_pkg holds:
  - the FSM state enum (IDLE/CONV/FIN);
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - BCD_W=4 and SUM_W=5.
- One sub-module, bcd_to_7seg: combinational 4-bit BCD -> 7-bit active-low segment decode, instantiated once after the digit mux.

Test Plan:
- Reset: hold rst=0, then release -> busy=0, done=0, an=10, seg=1000000. After REFRESH_DIV cycles, an=01 and seg=1000000.
- Max value: load with co=1, zi=1111 (31), REFRESH_DIV=4 ->
  - busy high for exactly 6 cycles after E0, done pulse after E6;
  - units slot seg=1111001 ("1"), tens slot seg=0110000 ("3").
- Carry-only value: co=1, zi=0000 (16) -> tens "1" = 1111001, units "6" = 0000010. A second load during busy with zi=0101 is ignored; the digits stay 16.
- Reset mid-conversion: load 25, drop rst at E3 -> busy=0 immediately. After release the digits are 00 and no done pulse occurs.
- Blanking: load co=0, zi=0111 (7) ->
  - with SUM_DISPLAY_BLANK_EN, tens slot seg=1111111 and units slot seg=1111000;
  - without the macro, tens slot seg=1000000.
- Back-to-back: load 9, then assert load in the done cycle with value 10 -> the second conversion starts; the display reads 09, then 10.
